// File: rtl/bin_div_pkg.sv
// Shared arithmetic definitions for the divider/multiplier block set:
// default operand width and the divider's control-state encoding.
package bin_div_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bin_div_step.sv
// One restoring-division stage: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when no borrow occurs.
module bin_div_step
   import bin_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] shifted_rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] next_rem_o,
   output logic             q_bit_o
);

   // One extra bit so the borrow lands in trial[WIDTH].
   logic [WIDTH:0] trial;

   assign trial      = {1'b0, shifted_rem_i} - {1'b0, divisor_i};
   assign q_bit_o    = ~trial[WIDTH];
   assign next_rem_o = trial[WIDTH] ? shifted_rem_i : trial[WIDTH-1:0];

endmodule

// File: rtl/bin_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// quotient/remainder presented with a one-cycle done pulse.
module bin_div
   import bin_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] step_shifted;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

   // The top bit of the partial remainder is always zero before a step,
   // so dropping it while shifting in the next dividend bit loses nothing.
   assign step_shifted = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

   bin_div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .shifted_rem_i(step_shifted),
      .divisor_i    (dvs_q),
      .next_rem_o   (step_rem),
      .q_bit_o      (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            ready = 1'b1;
            done  = (state_q == ST_DONE);
            if (start) begin
               if (divisor == '0) begin
                  state_d = ST_DONE;
                  quo_d   = '1;
                  rmd_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = ST_CALC;
                  dvd_d   = dividend;
                  dvs_d   = divisor;
                  rem_d   = '0;
                  acc_d   = '0;
                  cnt_d   = CW'(WIDTH - 1);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_CALC: begin
            busy  = 1'b1;
            rem_d = step_rem;
            acc_d = {acc_q[WIDTH-2:0], step_q};
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               quo_d   = {acc_q[WIDTH-2:0], step_q};
               rmd_d   = step_rem;
               dbz_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;

endmodule
